// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit for the MIPS execute stage.
// Computes mult/multu/div/divu into HI/LO in 33 cycles: 32 radix-2 steps plus one sign-fix cycle.
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [1:0]  MDOp,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic        HIWrite,
  input  logic        LOWrite,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state, state_next;
  logic [4:0]  cnt;
  logic        is_div;
  logic        neg_lo;
  logic        neg_hi;
  logic [31:0] b_mag;
  logic [63:0] acc;

  logic        op_signed;
  logic        a_neg, b_neg;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_take;
  logic [31:0] div_rem;
  logic [63:0] acc_step;
  logic [63:0] prod;
  logic [31:0] res_hi, res_lo;

  function automatic logic [31:0] mag32(input logic signed [31:0] v, input logic is_signed);
    return (is_signed && v < 0) ? 32'(-v) : 32'(v);
  endfunction

  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    return neg ? 32'(-v) : v;
  endfunction

  function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
    return neg ? 64'(-v) : v;
  endfunction

  assign op_signed = ~MDOp[0];
  assign a_neg     = op_signed & SrcA[31];
  assign b_neg     = op_signed & SrcB[31];

  // acc holds {partial product, multiplier} for mult and {remainder, dividend/quotient} for div
  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_mag} : 33'd0);
    div_shift = {acc[63:32], acc[31]};
    div_take  = div_shift >= {1'b0, b_mag};
    div_rem   = div_shift[31:0] - b_mag;
    if (is_div)
      acc_step = div_take ? {div_rem, acc[30:0], 1'b1} : {div_shift[31:0], acc[30:0], 1'b0};
    else
      acc_step = {mul_sum, acc[31:1]};
    prod   = cond_neg64(acc, neg_lo);
    res_hi = is_div ? cond_neg32(acc[63:32], neg_hi) : prod[63:32];
    res_lo = is_div ? cond_neg32(acc[31:0], neg_lo)  : prod[31:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = CALC;
      CALC:    if (cnt == 5'd31) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      Busy  <= 1'b0;
      cnt   <= 5'd0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      state <= state_next;
      Busy  <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (Start) begin
            cnt <= 5'd0;
          end else begin
            if (HIWrite) HI <= SrcA;
            if (LOWrite) LO <= SrcA;
          end
        end
        CALC: cnt <= cnt + 5'd1;
        FIX: begin
          HI <= res_hi;
          LO <= res_lo;
        end
        default: ;
      endcase
    end
  end

  // Divide by zero keeps the all-ones quotient unsigned-looking, so the quotient sign fix is skipped
  always_ff @(posedge clk) begin
    if (state == IDLE && Start) begin
      is_div <= MDOp[1];
      b_mag  <= mag32(SrcB, op_signed);
      acc    <= {32'd0, mag32(SrcA, op_signed)};
      neg_lo <= MDOp[1] ? ((a_neg ^ b_neg) & (SrcB != 32'd0)) : (a_neg ^ b_neg);
      neg_hi <= MDOp[1] ? a_neg : (a_neg ^ b_neg);
    end else if (state == CALC) begin
      acc <= acc_step;
    end
  end

endmodule
